// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer that borrows the execute-stage ALU for adds and shifts.
// Define MUL_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are zero.
module alu_mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicando,
  input  logic [XLEN-1:0] multiplicador,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] produto,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_entrada0,
  output logic [XLEN-1:0] alu_entrada1,
  input  logic [XLEN-1:0] alu_saida
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, FIN} state_t;

  state_t          state;
  logic [XLEN-1:0] acc, mcand, mplier;
  logic [CW-1:0]   count;
  logic            last;

`ifdef MUL_EARLY_EXIT_EN
  assign last = (count == CW'(XLEN-1)) || ((mplier >> 1) == '0);
`else
  assign last = (count == CW'(XLEN-1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      produto <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc    <= '0;
          mcand  <= multiplicando;
          mplier <= multiplicador;
          count  <= '0;
          busy   <= 1'b1;
          state  <= ADD;
        end
        ADD: begin
          if (mplier[0]) acc <= alu_saida;
          state <= SHIFT;
        end
        SHIFT: begin
          mcand  <= alu_saida;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last) begin
            // acc is stable in SHIFT, so it can be published on the way into FIN
            produto <= acc;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= FIN;
          end else begin
            state <= ADD;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    alu_control  = 4'b1111;
    alu_entrada0 = '0;
    alu_entrada1 = '0;
    case (state)
      ADD: begin
        alu_control  = 4'b0010;
        alu_entrada0 = acc;
        alu_entrada1 = mcand;
      end
      SHIFT: begin
        alu_control  = 4'b0100;
        alu_entrada0 = mcand;
        alu_entrada1 = XLEN'(1);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: table vectors, corner sequences and random ops vs a product model.
module tb_alu_mul_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] multiplicando = '0, multiplicador = '0;
  logic        busy, done;
  logic [31:0] produto;
  logic [3:0]  alu_control;
  logic [31:0] alu_entrada0, alu_entrada1, alu_saida;

  int checks = 0;
  int passed = 0;

  alu_mul_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicando(multiplicando), .multiplicador(multiplicador),
    .busy(busy), .done(done), .produto(produto),
    .alu_control(alu_control), .alu_entrada0(alu_entrada0),
    .alu_entrada1(alu_entrada1), .alu_saida(alu_saida)
  );

  always #5 clk = ~clk;

  // Stand-in for the execute-stage ALU
  always_comb begin
    alu_saida = alu_entrada0;
    case (alu_control)
      4'b0010: alu_saida = alu_entrada0 + alu_entrada1;
      4'b0100: alu_saida = alu_entrada0 << alu_entrada1[4:0];
      default: alu_saida = alu_entrada0;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic int iters(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction

  // Called just after the accepting edge; samples on negedges until done.
  task automatic wait_done(input string nm, input logic [31:0] exp_p, input int n);
    int cyc = 0;
    int busy_bad = 0, ctl_bad = 0;
    bit seen = 0;
    logic [31:0] hold;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1;
        if (busy) busy_bad++;
      end else begin
        if (!busy) busy_bad++;
        if (alu_control !== ((cyc % 2 == 1) ? 4'b0010 : 4'b0100)) ctl_bad++;
      end
    end
    check({nm, " latency"}, cyc, 2 * n + 1);
    check({nm, " produto"}, produto, exp_p);
    check({nm, " busy profile"}, busy_bad, 0);
    check({nm, " alu control seq"}, ctl_bad, 0);
    hold = produto;
    @(negedge clk);
    check({nm, " idle after done"}, {30'd0, busy, done}, 32'd0);
    check({nm, " produto hold"}, produto, hold);
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    multiplicando = a;
    multiplicador = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    multiplicando = ~a;
    multiplicador = b ^ 32'h5a5a_5a5a;
    wait_done(nm, a * b, iters(b));
  endtask

  vec_t vecs[6];

  initial begin
    int dn;
    logic [31:0] ra, rb;
    vecs[0] = '{32'd3,         32'd5,         32'd15};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2] = '{32'h1234_5678, 32'd0,         32'd0};
    vecs[3] = '{32'h8000_0000, 32'd2,         32'd0};
    vecs[4] = '{32'hFFFF_FFFD, 32'd4,         32'hFFFF_FFF4};
    vecs[5] = '{32'd7,         32'd6,         32'd42};

    #12;
    check("reset busy/done", {30'd0, busy, done}, 32'd0);
    check("reset produto", produto, 32'd0);
    check("reset alu_control", {28'd0, alu_control}, 32'hF);
    check("reset entradas", alu_entrada0 | alu_entrada1, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      check("table model", vecs[i].a * vecs[i].b, vecs[i].p);
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
    end

    // start held high across a whole op, operands changed mid-op
    @(negedge clk);
    multiplicando = 32'd7;
    multiplicador = 32'd6;
    start = 1'b1;
    @(posedge clk);
    #1 multiplicando = 32'd5;
    multiplicador = 32'd5;
    wait_done("held", 32'd42, iters(32'd6));
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("back2back", 32'd25, iters(32'd5));

    // reset mid-op
    @(negedge clk);
    multiplicando = 32'd9;
    multiplicador = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset busy/done", {30'd0, busy, done}, 32'd0);
    check("midreset produto", produto, 32'd0);
    check("midreset alu_control", {28'd0, alu_control}, 32'hF);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("no done after reset", dn, 0);
    run_op("after reset", 32'd9, 32'd9);

    for (int r = 0; r < 20; r++) begin
      ra = $urandom;
      case (r % 4)
        0: rb = $urandom;
        1: rb = $urandom_range(0, 15);
        2: rb = 32'd1 << $urandom_range(0, 31);
        default: rb = $urandom & 32'h0000_FFFF;
      endcase
      run_op($sformatf("rand%0d", r), ra, rb);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
